// File: rtl/clock_ctrl_pkg.sv
// Shared state encoding and field limits for the clock time-set controller.
package clock_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

  localparam logic [6:0] MAX_HOURS   = 7'd23;
  localparam logic [6:0] MAX_MINUTES = 7'd59;

endpackage

// File: rtl/wrap_updown.sv
// 7-bit edit register: parallel load with range clamp, wrapping increment/decrement.
module wrap_updown (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       inc,
  input  logic       dec,
  input  logic [6:0] max,
  input  logic       load,
  input  logic [6:0] load_val,
  output logic [6:0] value
);

  logic [6:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      // out-of-range live values restart editing from zero
      value_d = (load_val > max) ? 7'd0 : load_val;
    end else if (enable && inc && !dec) begin
      value_d = (value_q >= max) ? 7'd0 : value_q + 7'd1;
    end else if (enable && dec && !inc) begin
      value_d = (value_q == 7'd0) ? max : value_q - 7'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: mode button walks RUN -> SET_HR -> SET_MIN -> COMMIT,
// with blinking of the field being edited and an idle timeout that discards edits.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_RUN     | clock running, edit registers hold last capture
// ST_SET_HR  | hours field editable, hours digits blink
// ST_SET_MIN | minutes field editable, minutes digits blink
// ST_COMMIT  | one-cycle load strobe of edited time into counters
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int BLINK_TICKS   = 5,
  parameter int TIMEOUT_TICKS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_100ms,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [6:0] cur_hours,
  input  logic [6:0] cur_minutes,
  output logic [6:0] load_hours,
  output logic [6:0] load_minutes,
  output logic       load_en,
  output logic       run_en,
  output logic       blank_hours,
  output logic       blank_minutes,
  output logic [1:0] mode
);

  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS + 1) : 1;
  localparam int IW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_TICKS - 1);

  state_e        state_q, state_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          phase_q, phase_d;
  logic          load_en_q, run_en_q, blank_hours_q, blank_minutes_q;

  logic any_btn, editing, timeout, capture;

  assign any_btn = btn_mode | btn_inc | btn_dec;
  assign editing = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN);
  // a press in the timeout cycle wins: it clears the idle count instead
  assign timeout = editing && tick_100ms && !any_btn && (idle_q == IDLE_LAST);
  assign capture = (state_q == ST_RUN) && btn_mode;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (btn_mode) state_d = ST_SET_HR;
      ST_SET_HR:  if (btn_mode) state_d = ST_SET_MIN;
                  else if (timeout) state_d = ST_RUN;
      ST_SET_MIN: if (btn_mode) state_d = ST_COMMIT;
                  else if (timeout) state_d = ST_RUN;
      ST_COMMIT:  state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_comb begin
    blink_d = '0;
    phase_d = 1'b0;
    idle_d  = '0;
    if (editing && !any_btn && (state_d == state_q)) begin
      blink_d = blink_q;
      phase_d = phase_q;
      idle_d  = idle_q;
      if (tick_100ms) begin
        idle_d = idle_q + IW'(1);
        if (blink_q == BLINK_LAST) begin
          blink_d = '0;
          phase_d = ~phase_q;
        end else begin
          blink_d = blink_q + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_RUN;
      blink_q         <= '0;
      idle_q          <= '0;
      phase_q         <= 1'b0;
      load_en_q       <= 1'b0;
      run_en_q        <= 1'b1;
      blank_hours_q   <= 1'b0;
      blank_minutes_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      blink_q         <= blink_d;
      idle_q          <= idle_d;
      phase_q         <= phase_d;
      load_en_q       <= (state_d == ST_COMMIT);
      run_en_q        <= (state_d == ST_RUN) || (state_d == ST_COMMIT);
      blank_hours_q   <= (state_d == ST_SET_HR) && phase_d;
      blank_minutes_q <= (state_d == ST_SET_MIN) && phase_d;
    end
  end

  // mode press in an edit state advances only; the inc/dec is dropped
  wrap_updown u_hours (
    .clk      (clk),
    .reset    (reset),
    .enable   ((state_q == ST_SET_HR) && !btn_mode),
    .inc      (btn_inc),
    .dec      (btn_dec),
    .max      (MAX_HOURS),
    .load     (capture),
    .load_val (cur_hours),
    .value    (load_hours)
  );

  wrap_updown u_minutes (
    .clk      (clk),
    .reset    (reset),
    .enable   ((state_q == ST_SET_MIN) && !btn_mode),
    .inc      (btn_inc),
    .dec      (btn_dec),
    .max      (MAX_MINUTES),
    .load     (capture),
    .load_val (cur_minutes),
    .value    (load_minutes)
  );

  assign load_en       = load_en_q;
  assign run_en        = run_en_q;
  assign blank_hours   = blank_hours_q;
  assign blank_minutes = blank_minutes_q;
  assign mode          = state_q;

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter BLINK_TICKS, default 5, number of 100 ms ticks per blink half-period.
REQ-002 SHALL have parameter TIMEOUT_TICKS, default 100, number of idle 100 ms ticks before edit abort.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port tick_100ms  input  1  single-cycle enable every 100 ms.
REQ-006 SHALL have port btn_mode  input  1  debounced single-cycle mode press.
REQ-007 SHALL have port btn_inc  input  1  debounced single-cycle increment press.
REQ-008 SHALL have port btn_dec  input  1  debounced single-cycle decrement press.
REQ-009 SHALL have port cur_hours  input  7  live hours count, binary.
REQ-010 SHALL have port cur_minutes  input  7  live minutes count, binary.
REQ-011 SHALL have port load_hours  output  7  edited hours value.
REQ-012 SHALL have port load_minutes  output  7  edited minutes value.
REQ-013 SHALL have port load_en  output  1  single-cycle load strobe to the hours/minutes counters.
REQ-014 SHALL have port run_en  output  1  time-keeping enable; low while editing.
REQ-015 SHALL have port blank_hours  output  1  blank the hours digits (blink).
REQ-016 SHALL have port blank_minutes  output  1  blank the minutes digits (blink).
REQ-017 SHALL have port mode  output  2  current state: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 COMMIT.

Function
REQ-018 SHALL implement the FSM RUN -> SET_HR -> SET_MIN -> COMMIT -> RUN, with transitions on btn_mode except COMMIT -> RUN, which is unconditional after one cycle.
REQ-019 On RUN+btn_mode SHALL capture cur_hours/cur_minutes into the edit registers in the same edge; a captured hours value >23 or minutes value >59 SHALL load 0.
REQ-020 In SET_HR: inc SHALL add 1 with wrap 23->0; dec SHALL subtract 1 with wrap 0->23; minutes edit register unchanged.
REQ-021 In SET_MIN: inc SHALL add 1 with wrap 59->0; dec SHALL subtract 1 with wrap 0->59; hours edit register unchanged.
REQ-022 inc and dec asserted in the same cycle SHALL cause no change.
REQ-023 btn_mode asserted with inc or dec in the same cycle SHALL advance the state, and the inc/dec SHALL be ignored.
REQ-024 inc/dec in RUN or COMMIT SHALL be ignored.
REQ-025 COMMIT SHALL assert load_en for exactly one cycle, with load_hours/load_minutes equal to the edit registers.
REQ-026 load_hours/load_minutes SHALL continuously reflect the edit registers.
REQ-027 run_en SHALL be 1 in RUN and COMMIT, and 0 in SET_HR and SET_MIN; the output SHALL be registered.
REQ-028 The blink counter SHALL count tick_100ms in SET_HR/SET_MIN and toggle the phase every BLINK_TICKS ticks.
REQ-029 Any button press or state change SHALL reset the blink counter and set the phase to visible (0).
REQ-030 blank_hours SHALL equal the phase in SET_HR, else 0; blank_minutes SHALL equal the phase in SET_MIN, else 0.
REQ-031 The idle counter SHALL count tick_100ms in SET_HR/SET_MIN and clear on any button press.
REQ-032 When the idle count reaches TIMEOUT_TICKS, the block SHALL return to RUN without load_en, discarding the edits.
REQ-033 A button press in the same cycle as timeout SHALL take priority, so no abort occurs.
REQ-034 All outputs SHALL be registered; there is no combinational path from inputs to outputs.

Reset
REQ-035 While reset=0: state RUN, load_en 0, run_en 1, blank_* 0, load_* 0, mode 0, and all counters 0.
REQ-036 Reset asserted mid-edit SHALL abort with no load_en pulse; first state after release is RUN.

Structure
REQ-037 Package clock_ctrl_pkg SHALL hold the state encoding and the constants MAX_HOURS=23, MAX_MINUTES=59.
REQ-038 Sub-module wrap_updown (enable, inc, dec, max, load, load_val -> 7-bit value) SHALL be instantiated twice, once for hours and once for minutes.

Verification
REQ-039 Capture 10:45, mode, inc x3, mode, dec x50, mode -> load_en pulse with hours 13, minutes 55; run_en back to 1.
REQ-040 Capture 23:59, mode, inc, mode, inc, mode -> load values 0:00; then capture 0:00 and dec each field -> 23:59.
REQ-041 Enter SET_HR and press nothing for 100 ticks -> RUN at tick 100, no load_en, run_en 1.
REQ-042 Same-cycle inc+dec -> no change; same-cycle mode+inc in SET_HR -> SET_MIN with hours unchanged.
REQ-043 In SET_MIN -> blank_minutes toggles every 5 ticks and blank_hours stays 0; inc press forces blank_minutes 0.
REQ-044 Reset pulse during SET_MIN -> no load_en; outputs match REQ-035.
